// File: rtl/skid_pipeline.sv
// Chain of DEPTH two-entry skid stages: registered valid/data and ready paths, full throughput,
// synchronous flush and occupancy count. Define SKID_PIPELINE_PARITY_EN to add per-entry parity.
module skid_pipeline #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
`ifdef SKID_PIPELINE_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef SKID_PIPELINE_PARITY_EN
  localparam int unsigned EW = WIDTH + 1;
`else
  localparam int unsigned EW = WIDTH;
`endif

  logic [DEPTH-1:0] main_v;
  logic [DEPTH-1:0] skid_v;
  logic [EW-1:0]    main_d [DEPTH];
  logic [EW-1:0]    skid_d [DEPTH];
  logic [EW-1:0]    dchain [DEPTH];
  logic [EW-1:0]    in_entry;
  logic [DEPTH:0]   vchain;
  logic [DEPTH:0]   rchain;
  logic [DEPTH:0]   xfer;
  logic             rdy_en;

`ifdef SKID_PIPELINE_PARITY_EN
  assign in_entry = {^wdata, wdata};
`else
  assign in_entry = wdata;
`endif

  // Handshake at every boundary: xfer[k] moves a word into stage k, xfer[DEPTH] leaves the block.
  always_comb begin
    vchain = '0;
    rchain = '0;
    for (int k = 0; k < DEPTH; k++) begin
      dchain[k] = '0;
    end
    vchain[0] = in_valid;
    dchain[0] = in_entry;
    for (int k = 1; k <= DEPTH; k++) begin
      vchain[k] = main_v[k-1];
    end
    for (int k = 1; k < DEPTH; k++) begin
      dchain[k] = main_d[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      rchain[k] = ~skid_v[k];
    end
    rchain[DEPTH] = out_ready;
    xfer    = vchain & rchain & {(DEPTH+1){~flush}};
    xfer[0] = xfer[0] & rdy_en;
  end

  assign in_ready  = rchain[0] & rdy_en & ~flush;
  assign out_valid = main_v[DEPTH-1] & ~flush;
  assign rdata     = main_d[DEPTH-1][WIDTH-1:0];

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= '0;
      skid_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        main_d[k] <= '0;
        skid_d[k] <= '0;
      end
    end else if (flush) begin
      main_v <= '0;
      skid_v <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!main_v[k]) begin
          if (xfer[k]) begin
            main_v[k] <= 1'b1;
            main_d[k] <= dchain[k];
          end
        end else if (!skid_v[k]) begin
          if (xfer[k+1] && xfer[k]) begin
            main_d[k] <= dchain[k];
          end else if (xfer[k+1]) begin
            main_v[k] <= 1'b0;
          end else if (xfer[k]) begin
            skid_v[k] <= 1'b1;
            skid_d[k] <= dchain[k];
          end
        end else if (xfer[k+1]) begin
          main_d[k] <= skid_d[k];
          skid_v[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({xfer[0], xfer[DEPTH]})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SKID_PIPELINE_PARITY_EN
  logic [EW-1:0] last_d;
  assign last_d = main_d[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= xfer[DEPTH] & ((^last_d[WIDTH-1:0]) != last_d[WIDTH]);
  end
`endif

endmodule
